// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/advance enables for a 5-stage pipeline.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipeline_hazard_ctrl (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_dMemREN,
    input  logic [4:0]  ex_writeReg,
    input  logic        ex_branch_taken,
    input  logic        mem_dmem_req,
    input  logic        mem_halt,
    output logic        pc_writeEN,
    output logic        ifid_writeEN,
    output logic        idex_writeEN,
    output logic        exmem_writeEN,
    output logic        memwb_writeEN,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        halt,
    output logic [1:0]  state,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDUSE   = 2'd1,
        MEMWAIT = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t     cur_state;
    state_t     nxt_state;
    logic [4:0] we;
    logic [2:0] fl;
    logic       load_use;
    logic       branch_flush;

    assign state = cur_state;
    assign load_use = ex_dMemREN && (ex_writeReg != 5'd0) &&
                      ((ex_writeReg == id_rs) || (ex_writeReg == id_rt));

    // we = {pc, ifid, idex, exmem, memwb}; fl = {ifid, idex, exmem}
    always_comb begin
        we           = 5'b11111;
        fl           = 3'b000;
        halt         = 1'b0;
        branch_flush = 1'b0;
        nxt_state    = RUN;
        if (!nRST) begin
            we = 5'b00000;
            fl = 3'b111;
        end else if (cur_state == HALT) begin
            we        = 5'b00000;
            halt      = 1'b1;
            nxt_state = HALT;
        end else if (mem_halt) begin
            we        = 5'b00000;
            nxt_state = HALT;
        end else if (!dhit && ((cur_state == MEMWAIT) || mem_dmem_req)) begin
            we        = 5'b00000;
            nxt_state = MEMWAIT;
        end else if (ex_branch_taken) begin
            fl           = 3'b110;
            branch_flush = 1'b1;
        end else if ((cur_state == RUN) && load_use) begin
            // Hold PC and IF/ID, bubble into ID/EX while the load completes.
            we        = 5'b00111;
            fl        = 3'b010;
            nxt_state = LDUSE;
        end else if (!ihit) begin
            we = 5'b01111;
            fl = 3'b100;
        end
    end

    assign pc_writeEN    = we[4];
    assign ifid_writeEN  = we[3];
    assign idex_writeEN  = we[2];
    assign exmem_writeEN = we[1];
    assign memwb_writeEN = we[0];
    assign ifid_flush    = fl[2];
    assign idex_flush    = fl[1];
    assign exmem_flush   = fl[0];

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cur_state <= RUN;
        end else begin
            cur_state <= nxt_state;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (!pc_writeEN && (cur_state != HALT) && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (branch_flush && (flush_q != 32'hFFFF_FFFF)) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors, expected queue, monitor.
module tb_pipeline_hazard_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Expected word: {state[1:0], halt, we{pc,ifid,idex,exmem,memwb}, fl{ifid,idex,exmem}}
    localparam logic [10:0] E_IDLE  = {2'd0, 1'b0, 5'b11111, 3'b000};
    localparam logic [10:0] E_LDUSE = {2'd0, 1'b0, 5'b00111, 3'b010};
    localparam logic [10:0] E_LDCYC = {2'd1, 1'b0, 5'b11111, 3'b000};
    localparam logic [10:0] E_DWAIT = {2'd0, 1'b0, 5'b00000, 3'b000};
    localparam logic [10:0] E_MWAIT = {2'd2, 1'b0, 5'b00000, 3'b000};
    localparam logic [10:0] E_MDONE = {2'd2, 1'b0, 5'b11111, 3'b000};
    localparam logic [10:0] E_MDBR  = {2'd2, 1'b0, 5'b11111, 3'b110};
    localparam logic [10:0] E_BR    = {2'd0, 1'b0, 5'b11111, 3'b110};
    localparam logic [10:0] E_FMISS = {2'd0, 1'b0, 5'b01111, 3'b100};
    localparam logic [10:0] E_HALT  = {2'd3, 1'b1, 5'b00000, 3'b000};

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit;
    logic [4:0]  id_rs, id_rt;
    logic        ex_dMemREN;
    logic [4:0]  ex_writeReg;
    logic        ex_branch_taken, mem_dmem_req, mem_halt;
    logic        pc_writeEN, ifid_writeEN, idex_writeEN, exmem_writeEN, memwb_writeEN;
    logic        ifid_flush, idex_flush, exmem_flush;
    logic        halt;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt;

    // queue entry: {check_counters, stall[31:0], flush[31:0], ctrl[10:0]}
    logic [75:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    bit          stim_done = 1'b0;

    pipeline_hazard_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .id_rs(id_rs), .id_rt(id_rt), .ex_dMemREN(ex_dMemREN), .ex_writeReg(ex_writeReg),
        .ex_branch_taken(ex_branch_taken), .mem_dmem_req(mem_dmem_req), .mem_halt(mem_halt),
        .pc_writeEN(pc_writeEN), .ifid_writeEN(ifid_writeEN), .idex_writeEN(idex_writeEN),
        .exmem_writeEN(exmem_writeEN), .memwb_writeEN(memwb_writeEN),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .halt(halt), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    // driver: apply one cycle of inputs at the falling edge, optionally queue the expected response
    task automatic drv(input bit rst_n, input bit ih, input bit dh, input bit mr, input bit mh,
                       input bit br, input bit ren, input logic [4:0] wr, input logic [4:0] rs,
                       input logic [4:0] rt, input bit chk, input logic [10:0] exp);
        @(negedge CLK);
        nRST = rst_n; ihit = ih; dhit = dh; mem_dmem_req = mr; mem_halt = mh;
        ex_branch_taken = br; ex_dMemREN = ren; ex_writeReg = wr; id_rs = rs; id_rt = rt;
        if (chk) exp_q.push_back({1'b0, 32'd0, 32'd0, exp});
    endtask

    task automatic idle_cnt(input logic [31:0] es, input logic [31:0] ef);
        @(negedge CLK);
        nRST = 1'b1; ihit = 1'b1; dhit = 1'b1; mem_dmem_req = 1'b0; mem_halt = 1'b0;
        ex_branch_taken = 1'b0; ex_dMemREN = 1'b0; ex_writeReg = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        exp_q.push_back({1'b1, (PERF ? es : 32'd0), (PERF ? ef : 32'd0), E_IDLE});
    endtask

    // monitor / scoreboard: outputs are presented every cycle, sampled mid-low-phase
    initial begin
        logic [75:0] e;
        logic [10:0] act;
        forever begin
            @(negedge CLK);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                act = {state, halt, pc_writeEN, ifid_writeEN, idex_writeEN, exmem_writeEN,
                       memwb_writeEN, ifid_flush, idex_flush, exmem_flush};
                total++;
                if (act !== e[10:0]) begin
                    bad++;
                    $display("FAIL ctrl t=%0t got=%b want=%b", $time, act, e[10:0]);
                end
                if (e[75]) begin
                    total++;
                    if (stall_cnt !== e[74:43]) begin
                        bad++;
                        $display("FAIL stall_cnt got=%0d want=%0d", stall_cnt, e[74:43]);
                    end
                    total++;
                    if (flush_cnt !== e[42:11]) begin
                        bad++;
                        $display("FAIL flush_cnt got=%0d want=%0d", flush_cnt, e[42:11]);
                    end
                end
            end
        end
    end

    initial begin
        //  rst ih dh mr mh br ren wr  rs  rt  chk exp
        drv(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
        drv(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, {2'd0, 1'b0, 5'b00000, 3'b111});
        idle_cnt(32'd0, 32'd0);
        // load-use on rs, then one LDUSE cycle with detection suppressed
        drv(1, 1, 1, 0, 0, 0, 1, 5, 5, 0, 1, E_LDUSE);
        drv(1, 1, 1, 0, 0, 0, 1, 5, 5, 0, 1, E_LDCYC);
        drv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, E_IDLE);
        // $zero destination never stalls; then a load-use on rt
        drv(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, E_IDLE);
        drv(1, 1, 1, 0, 0, 0, 1, 7, 3, 7, 1, E_LDUSE);
        drv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, E_LDCYC);
        // data wait: three dhit=0 cycles, then dhit
        drv(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, E_DWAIT);
        drv(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, E_MWAIT);
        drv(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, E_MWAIT);
        drv(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, E_MDONE);
        drv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, E_IDLE);
        // branch evaluated in the dhit cycle of MEMWAIT
        drv(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, E_DWAIT);
        drv(1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 1, E_MDBR);
        drv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, E_IDLE);
        // branch beats load-use in the same cycle
        drv(1, 1, 1, 0, 0, 1, 1, 5, 5, 0, 1, E_BR);
        drv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, E_IDLE);
        // fetch miss
        drv(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, E_FMISS);
        idle_cnt(32'd7, 32'd2);
        // halt wins over a data wait and is sticky against other events
        drv(1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, E_IDLE);
        drv(1, 0, 1, 0, 0, 1, 1, 5, 5, 0, 1, E_HALT);
        drv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, E_HALT);
        drv(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, {2'd3, 1'b0, 5'b00000, 3'b111});
        drv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, E_IDLE);
        // reset mid-MEMWAIT and mid-LDUSE
        drv(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, E_DWAIT);
        drv(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, {2'd2, 1'b0, 5'b00000, 3'b111});
        drv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, E_IDLE);
        drv(1, 1, 1, 0, 0, 0, 1, 9, 0, 9, 1, E_LDUSE);
        drv(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, {2'd1, 1'b0, 5'b00000, 3'b111});
        idle_cnt(32'd0, 32'd0);
        // counters: four fetch-miss stalls and two branch flushes
        for (int i = 0; i < 4; i++) drv(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, E_FMISS);
        for (int i = 0; i < 2; i++) drv(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1, E_BR);
        idle_cnt(32'd4, 32'd2);
        stim_done = 1'b1;
    end

    // final report
    initial begin
        int guard = 0;
        nRST = 1'b0; ihit = 1'b1; dhit = 1'b1; mem_dmem_req = 1'b0; mem_halt = 1'b0;
        ex_branch_taken = 1'b0; ex_dMemREN = 1'b0; ex_writeReg = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        while (!(stim_done && exp_q.size() == 0) && guard < 2000) begin
            @(posedge CLK);
            guard++;
        end
        @(negedge CLK);
        #4;
        if (guard >= 2000 || exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
